// File: rtl/myproject_dense_acc_relu.sv
`default_nettype none
// ============================================================================
// Module   : myproject_dense_acc_relu
// Purpose  : Dense-layer neuron back end. Accumulates N_IN signed products
//            from the upstream multiplier, seeded with the neuron bias. It then
//            rescales the sum by an arithmetic right shift, applies an optional
//            ReLU, saturates to the activation width and presents the result
//            over a valid/ready handshake. in_ready doubles as the
//            multiplier's clock enable, so output backpressure freezes the
//            multiplier pipeline.
// Ports    : clk        - rising-edge clock
//            reset      - asynchronous reset, active-low
//            prod_valid - prod_data valid this cycle
//            prod_data  - signed product (PROD_WIDTH)
//            bias_data  - signed bias, sampled with the first product
//            in_ready   - block accepts products (multiplier ce)
//            out_valid  - out_data valid
//            out_ready  - downstream accepts out_data
//            out_data   - signed activation (OUT_WIDTH)
//            acc_ovf    - sticky accumulator-saturation flag
// Revision : 1.0 - initial release
// ============================================================================
module myproject_dense_acc_relu #(
    parameter int PROD_WIDTH = 22,
    parameter int BIAS_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int FRAC_SHIFT = 6,
    parameter int N_IN       = 16,
    parameter int RELU       = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  prod_valid,
    input  logic [PROD_WIDTH-1:0] prod_data,
    input  logic [BIAS_WIDTH-1:0] bias_data,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  acc_ovf
);

    localparam int CNT_WIDTH = $clog2(N_IN + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(N_IN - 1);

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    // Activation limits expressed at accumulator width so the clamp compares
    // like-signed, like-sized values.
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        ACC_WIDTH'($signed({1'b0, {(OUT_WIDTH-1){1'b1}}}));
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN =
        ACC_WIDTH'($signed({1'b1, {(OUT_WIDTH-1){1'b0}}}));

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [1:0]                  state;
    logic [1:0]                  state_next;
    logic signed [ACC_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0]        cnt;

    logic                        accept;
    logic                        first_load;
    logic                        finish;
    logic                        handshake;
    logic                        in_ready_next;
    logic                        out_valid_next;

    logic signed [ACC_WIDTH:0]   add_a;
    logic signed [ACC_WIDTH:0]   add_b;
    logic signed [ACC_WIDTH:0]   sum_wide;
    logic                        sum_ovf;
    logic signed [ACC_WIDTH-1:0] sum_sat;
    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [ACC_WIDTH-1:0] rectified;
    logic signed [ACC_WIDTH-1:0] clamped;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = (N_IN == 1) ? S_OUT : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept && (cnt == CNT_LAST)) begin
                    state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output / control decode
    // ------------------------------------------------------------------------
    always_comb begin
        accept         = prod_valid && in_ready;
        first_load     = accept && (state == S_IDLE);
        finish         = accept && (state_next == S_OUT);
        handshake      = (state == S_OUT) && out_ready;
        // Handshake flags are registered from the next state, so they track
        // the state register exactly and never glitch toward the multiplier.
        in_ready_next  = (state_next != S_OUT);
        out_valid_next = (state_next == S_OUT);
    end

    // ------------------------------------------------------------------------
    // Datapath arithmetic
    // ------------------------------------------------------------------------
    always_comb begin
        // One guard bit above the accumulator detects signed overflow; the
        // bias replaces the running sum for the first product of a neuron.
        add_a    = first_load ? (ACC_WIDTH+1)'($signed(bias_data))
                              : {acc[ACC_WIDTH-1], acc};
        add_b    = (ACC_WIDTH+1)'($signed(prod_data));
        sum_wide = add_a + add_b;
        sum_ovf  = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];

        if (sum_ovf) begin
            sum_sat = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_sat = sum_wide[ACC_WIDTH-1:0];
        end

        // Arithmetic shift of a signed value rounds toward minus infinity.
        shifted = sum_sat >>> FRAC_SHIFT;

        if ((RELU != 0) && (shifted < 0)) begin
            rectified = '0;
        end else begin
            rectified = shifted;
        end

        if (rectified > OUT_MAX) begin
            clamped = OUT_MAX;
        end else if (rectified < OUT_MIN) begin
            clamped = OUT_MIN;
        end else begin
            clamped = rectified;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath and handshake registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            cnt       <= '0;
            acc_ovf   <= 1'b0;
            out_data  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= in_ready_next;
            out_valid <= out_valid_next;

            if (accept) begin
                acc <= sum_sat;
                cnt <= first_load ? CNT_WIDTH'(1) : cnt + CNT_WIDTH'(1);
                if (sum_ovf) begin
                    acc_ovf <= 1'b1;
                end
            end

            // The activation is taken from the final sum as it is written,
            // so it is ready in the same cycle out_valid rises and is then
            // held untouched until the handshake completes.
            if (finish) begin
                out_data <= clamped[OUT_WIDTH-1:0];
            end

            if (handshake) begin
                cnt <= '0;
                acc <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_myproject_dense_acc_relu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_myproject_dense_acc_relu
// Purpose  : Self-checking bench. Two instances share one stimulus stream:
//            A uses the default parameters (ReLU, 32-bit accumulator) and B
//            passes signed results through a 24-bit accumulator, so the
//            saturation and no-ReLU paths are exercised together. Expected
//            results come from a plain-integer neuron model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_myproject_dense_acc_relu;

    localparam int N     = 16;
    localparam int SCALE = 64;

    typedef int prods_t [N];

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               prod_valid = 1'b0;
    logic [21:0]        prod_data = '0;
    logic [15:0]        bias_data = '0;
    logic               out_ready = 1'b0;

    logic               in_ready_a, out_valid_a, acc_ovf_a;
    logic signed [15:0] out_data_a;
    logic               in_ready_b, out_valid_b, acc_ovf_b;
    logic signed [15:0] out_data_b;

    int vectors     = 0;
    int miscompares = 0;
    bit ovf_a_exp   = 1'b0;
    bit ovf_b_exp   = 1'b0;

    always #5 clk = ~clk;

    myproject_dense_acc_relu dut_a (
        .clk        (clk),
        .reset      (reset),
        .prod_valid (prod_valid),
        .prod_data  (prod_data),
        .bias_data  (bias_data),
        .in_ready   (in_ready_a),
        .out_valid  (out_valid_a),
        .out_ready  (out_ready),
        .out_data   (out_data_a),
        .acc_ovf    (acc_ovf_a)
    );

    myproject_dense_acc_relu #(
        .ACC_WIDTH (24),
        .RELU      (0)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .prod_valid (prod_valid),
        .prod_data  (prod_data),
        .bias_data  (bias_data),
        .in_ready   (in_ready_b),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready),
        .out_data   (out_data_b),
        .acc_ovf    (acc_ovf_b)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Neuron reference: bias plus products with a clamped running sum,
    // floor division by 2^6, optional rectification, clamp to 16 bits.
    function automatic void model(input int bias, input prods_t p, input int acc_w,
                                  input bit relu, output longint res, output bit ovf);
        longint acc, hi, lo, r;
        hi  = (longint'(1) << (acc_w - 1)) - 1;
        lo  = -(longint'(1) << (acc_w - 1));
        acc = bias;
        ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            acc = acc + p[i];
            if (acc > hi) begin
                acc = hi;
                ovf = 1'b1;
            end else if (acc < lo) begin
                acc = lo;
                ovf = 1'b1;
            end
        end
        if (acc >= 0) r = acc / SCALE;
        else          r = -((-acc + SCALE - 1) / SCALE);
        if (relu && r < 0) r = 0;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        res = r;
    endfunction

    function automatic int srand(input int bits);
        int t;
        t = int'($urandom);
        return (t <<< (32 - bits)) >>> (32 - bits);
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, ":in_ready"},  in_ready_a,  1);
        check({tag, ":out_valid"}, out_valid_a, 0);
        check({tag, ":out_data"},  out_data_a,  0);
        check({tag, ":acc_ovf_a"}, acc_ovf_a,   0);
        check({tag, ":acc_ovf_b"}, acc_ovf_b,   0);
    endtask

    // Called and returns at a falling edge. Drives one neuron, optionally with
    // random valid gaps, holds out_ready low for 'stall' cycles with junk
    // products offered, then completes the handshake.
    task automatic run_neuron(input string name, input int bias, input prods_t p,
                              input bit gaps, input int stall);
        longint ea, eb;
        bit     oa, ob;
        int     idx = 0;
        int     cyc = 0;
        model(bias, p, 32, 1'b1, ea, oa);
        model(bias, p, 24, 1'b0, eb, ob);
        ovf_a_exp = ovf_a_exp | oa;
        ovf_b_exp = ovf_b_exp | ob;

        while (idx < N && cyc < 200) begin
            check({name, ":in_ready_acc"},  in_ready_a,  1);
            check({name, ":out_valid_acc"}, out_valid_a, 0);
            if (gaps && $urandom_range(0, 1) == 1) begin
                prod_valid = 1'b0;
                prod_data  = 22'($urandom);
            end else begin
                prod_valid = 1'b1;
                prod_data  = p[idx][21:0];
                bias_data  = (idx == 0) ? bias[15:0] : 16'($urandom);
                idx++;
            end
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
        check({name, ":feed_bound"}, idx, N);

        // One cycle after the last accept.
        prod_valid = 1'b1;
        prod_data  = 22'($urandom);
        out_ready  = 1'b0;
        check({name, ":out_valid"},   out_valid_a, 1);
        check({name, ":in_ready_out"}, in_ready_a, 0);
        check({name, ":out_valid_b"}, out_valid_b, 1);
        check({name, ":out_data_a"},  out_data_a,  ea);
        check({name, ":out_data_b"},  out_data_b,  eb);
        check({name, ":acc_ovf_a"},   acc_ovf_a,   ovf_a_exp);
        check({name, ":acc_ovf_b"},   acc_ovf_b,   ovf_b_exp);

        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            prod_data = 22'($urandom);
            check({name, ":stall_valid"}, out_valid_a, 1);
            check({name, ":stall_ready"}, in_ready_a,  0);
            check({name, ":stall_data"},  out_data_a,  ea);
        end

        out_ready = 1'b1;
        @(negedge clk);
        check({name, ":post_valid"}, out_valid_a, 0);
        check({name, ":post_ready"}, in_ready_a,  1);
        prod_valid = 1'b0;
        out_ready  = 1'b0;
    endtask

    initial begin
        prod_t_init : begin end
    end

    initial begin
        prods_t p;

        // Reset is asserted from time zero.
        #12;
        check_reset_state("reset0");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 1: bias 0, 16 x 64 -> 16
        for (int i = 0; i < N; i++) p[i] = 64;
        run_neuron("t1", 0, p, 1'b0, 0);

        // 2: bias -128, 16 x 8 -> 0; then 16 x -64 -> ReLU 0 / signed -16
        for (int i = 0; i < N; i++) p[i] = 8;
        run_neuron("t2a", -128, p, 1'b0, 0);
        for (int i = 0; i < N; i++) p[i] = -64;
        run_neuron("t2b", 0, p, 1'b0, 0);

        // 3: max positive products; output saturates, 24-bit accumulator overflows
        for (int i = 0; i < N; i++) p[i] = (1 << 21) - 1;
        run_neuron("t3", 0, p, 1'b0, 0);

        // 4: 5-cycle stall with junk products offered, then back-to-back neuron
        for (int i = 0; i < N; i++) p[i] = srand(12);
        run_neuron("t4a", srand(16), p, 1'b0, 5);
        for (int i = 0; i < N; i++) p[i] = 64;
        run_neuron("t4b", 0, p, 1'b0, 0);

        // 5: reset after 7 of 16 products; no residue afterwards
        for (int i = 0; i < 7; i++) begin
            prod_valid = 1'b1;
            prod_data  = 22'(1000);
            bias_data  = 16'(500);
            @(negedge clk);
        end
        prod_valid = 1'b0;
        reset      = 1'b0;
        #1;
        check_reset_state("reset_mid");
        @(negedge clk);
        reset     = 1'b1;
        ovf_a_exp = 1'b0;
        ovf_b_exp = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) p[i] = 64;
        run_neuron("t5", 0, p, 1'b0, 0);

        // 6: random valid gaps
        run_neuron("t6", 0, p, 1'b1, 0);

        // Random neurons
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < N; i++) p[i] = ($urandom_range(0, 3) == 0) ? srand(22) : srand(13);
            run_neuron($sformatf("rnd%0d", n), srand(16), p,
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
